// File: rtl/edge_result_writer_if.sv
// Magnitude input stream and frame-memory write port of the Sobel edge writer.
// The writer sits on the slave side; the surrounding pipeline/memory on the master side.
interface edge_result_writer_if #(
  parameter int MAG_W  = 30,
  parameter int ADDR_W = 4,
  parameter int PIX_W  = 8
);
  logic              mag_valid;
  logic [MAG_W-1:0]  mag_data;
  logic              mag_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [PIX_W-1:0]  mem_wr_data;
  logic              mem_wr_ready;

  modport master (
    output mag_valid, mag_data, mem_wr_ready,
    input  mag_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  mag_valid, mag_data, mem_wr_ready,
    output mag_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/edge_result_writer.sv
// Sobel output sink: saturates/binarises edge magnitudes, buffers them in a
// 4-entry FIFO and writes them to frame memory at sequential addresses.
module edge_result_writer #(
  parameter int MAG_W        = 30,
  parameter int WINDOW_COUNT = 9,
  parameter int ADDR_W       = 4,
  parameter int PIX_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [PIX_W-1:0]  threshold_i,
  input  logic              bin_mode_i,
  edge_result_writer_if.slave bus,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] sat_count_o
);

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int OCC_W = 3;
  localparam int CNT_W = $clog2(WINDOW_COUNT + 1);
  localparam logic [PIX_W-1:0] PIX_MAX   = '1;
  localparam logic [MAG_W-1:0] SAT_LIMIT = {{(MAG_W-PIX_W){1'b0}}, PIX_MAX};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sat_q, sat_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [PIX_W-1:0]  fifo_q [DEPTH];

  logic              clear;
  logic              accept;
  logic              transfer;
  logic              last_accept;
  logic              is_sat;
  logic [PIX_W-1:0]  sat_pix;
  logic [PIX_W-1:0]  pix;

  always_comb begin
    is_sat  = bus.mag_data > SAT_LIMIT;
    sat_pix = is_sat ? PIX_MAX : bus.mag_data[PIX_W-1:0];
    pix     = sat_pix;
    if (bin_mode_i) begin
      pix = (sat_pix >= threshold_i) ? PIX_MAX : '0;
    end
  end

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot early.
  assign bus.mag_ready   = (state_q == RUN) && (occ_q != OCC_W'(DEPTH)) &&
                           (in_cnt_q < CNT_W'(WINDOW_COUNT));
  assign accept          = bus.mag_valid && bus.mag_ready;
  assign last_accept     = accept && (in_cnt_q == CNT_W'(WINDOW_COUNT - 1));
  assign bus.mem_wr_en   = (occ_q != '0);
  assign bus.mem_wr_data = bus.mem_wr_en ? fifo_q[rd_ptr_q] : '0;
  assign bus.mem_wr_addr = addr_q;
  assign transfer        = bus.mem_wr_en && bus.mem_wr_ready;
  assign busy_o          = (state_q == RUN) || (state_q == DRAIN);
  assign done_o          = (state_q == DONE);
  assign sat_count_o     = sat_q;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_q == '0) || (transfer && (occ_q == OCC_W'(1)))) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_cnt_d = in_cnt_q;
    addr_d   = addr_q;
    sat_d    = sat_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      in_cnt_d = '0;
      addr_d   = '0;
      sat_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (accept) begin
        in_cnt_d = in_cnt_q + CNT_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        sat_d    = sat_q + ADDR_W'(is_sat);
      end
      if (transfer) begin
        addr_d   = addr_q + ADDR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({accept, transfer})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      addr_q   <= '0;
      sat_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      addr_q   <= addr_d;
      sat_q    <= sat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the read port is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= pix;
    end
  end

endmodule

// File: doc/edge_result_writer.md
# edge_result_writer

Output-side sink for the Sobel edge pipeline. It accepts one edge magnitude per window from the square-root stage over a valid/ready handshake. Each magnitude is saturated to an 8-bit pixel, optionally binarised against a threshold, and buffered in a 4-entry FIFO. Buffered pixels are written to the output frame memory at sequential addresses, and `done` is raised once all `window_count` results have been written.

## Interface
- `mag_data_size`, 30: edge magnitude width; equals the square-root output width.
- `window_count`, 9: results per frame.
- `addr_width`, 4: memory address width; requires 2^addr_width ≥ window_count.
- `pix_size`, 8: output pixel width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame start pulse.
- `mag_valid` in 1: a magnitude is offered.
- `mag_data` in mag_data_size: magnitude value, unsigned.
- `mag_ready` out 1: the block accepts the offered magnitude.
- `threshold` in pix_size: binarisation threshold; sampled on each accepted input.
- `bin_mode` in 1: 1 selects binary output, 0 selects grey output; sampled on each accepted input.
- `mem_wr_en` out 1: write request to the frame memory.
- `mem_wr_addr` out addr_width: write address.
- `mem_wr_data` out pix_size: write data.
- `mem_wr_ready` in 1: the memory accepts the current write.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: frame complete; held high in DONE.
- `sat_count` out addr_width: number of inputs in the current frame with mag_data > 255.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE. The reset state is IDLE.
- IDLE:
  - `start` moves the FSM to RUN.
  - On that transition, the input counter, write address and `sat_count` clear to 0 and the FIFO is emptied.
- RUN:
  - `mag_ready` = (FIFO not full) and (in_cnt < window_count).
  - An accept is `mag_valid` and `mag_ready` in the same cycle; each accept pushes one pixel and increments in_cnt.
  - The accept that makes in_cnt equal to window_count moves the FSM to DRAIN in the next cycle.
- DRAIN:
  - `mag_ready` = 0.
  - The FSM moves to DONE when the FIFO is empty and the last write has been accepted.
- DONE:
  - `done` = 1.
  - `start` re-enters RUN with the same clears as from IDLE.
- `start` is ignored in RUN and DRAIN.
- Pixel function, applied at push:
  - sat = (mag_data > 255) ? 255 : mag_data[7:0].
  - When `bin_mode` = 1: out = (sat ≥ threshold) ? 255 : 0.
  - When `bin_mode` = 0: out = sat.
  - `sat_count` increments when mag_data > 255, independent of `bin_mode`.
- Write port:
  - `mem_wr_en` = FIFO not empty. `mem_wr_data` is the FIFO head.
  - A write transfer is `mem_wr_en` and `mem_wr_ready` in the same cycle. Each transfer pops the FIFO head and increments `mem_wr_addr`.
  - While `mem_wr_en` is high and `mem_wr_ready` is low, data and address are held stable.
  - Addresses run 0 to window_count−1; the address does not wrap within a frame.
- A push and a pop in the same cycle leave the occupancy unchanged. `mag_ready` depends only on the occupancy registered at the start of the cycle; there is no bypass from a pop in the same cycle.
- `reset` asserted at any time, including mid-frame:
  - The FSM returns to IDLE, the FIFO empties and all counters clear.
  - Any queued pixels are discarded and no further writes are issued.

## Timing
- Reset values: `mag_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `sat_count`=0.
- `start` sampled at edge T:
  - `busy`=1 and `mag_ready`=1 from T+1.
  - `done` falls at T+1.
- Input to memory latency is 1 cycle: with an empty FIFO, a pixel accepted at edge N appears on `mem_wr_en`/`mem_wr_data` after N, and transfers at N+1 if `mem_wr_ready`=1.
- Sustained throughput is 1 pixel per cycle when `mem_wr_ready` is held high.
- Completion: the final write transfers at edge W. The FSM enters DONE at W+1, where `done`=1 and `busy`=0.
- With a stalled memory, at most 4 inputs are accepted beyond the last written pixel. `mag_ready` falls in the cycle after the FIFO reaches 4 entries.
- `window_count`=1: a single accept moves the FSM straight to DRAIN.

## Test plan
- **Basic frame.** `bin_mode`=0, `mem_wr_ready`=1, magnitudes 0,1,…,8 on consecutive cycles → writes at addresses 0–8 with data 0–8, one per cycle. `done` rises 1 cycle after the address-8 write; `sat_count`=0.
- **Saturation.** Magnitudes 256, 1000, 2^30−1, 255 → data 255, 255, 255, 255; `sat_count`=3.
- **Binarisation.** `threshold`=100, `bin_mode`=1, magnitudes 99, 100, 300 → data 0, 255, 255; `sat_count`=1.
- **Backpressure.** Hold `mem_wr_ready`=0 with `mag_valid`=1 continuously → exactly 4 accepts, then `mag_ready`=0, with `mem_wr_addr`=0 and its data held stable. Release `mem_wr_ready` → in-order writes at addresses 0,1,2,… and all 9 written.
- **Reset mid-frame.** Drop `reset` after 5 accepts with 2 pixels queued → all outputs at reset values immediately. A following `start` writes from address 0 again.
- **Restart and ignored start.** A `start` pulse during RUN has no effect. A `start` in DONE clears `done` next cycle and runs a second frame from address 0 with `sat_count` reset.
